// File: rtl/mem_repair_pkg.sv
// Shared types and defaults for the memory-repair sequencer.
package mem_repair_pkg;

  localparam int DEF_NUM_GRP = 7;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    REQ     = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_repair_seq.sv
// Walks enabled memory groups in ascending order, running a 4-phase
// req/ack repair handshake with each and collecting done/fail status.
module mem_repair_seq
  import mem_repair_pkg::*;
#(
  parameter int NUM_GRP = DEF_NUM_GRP,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               repair_en,
  input  logic [NUM_GRP-1:0] grp_mask,
  input  logic [NUM_GRP-1:0] grp_ack,
  input  logic [NUM_GRP-1:0] grp_fail,
  output logic [NUM_GRP-1:0] grp_req,
  output logic [NUM_GRP-1:0] repair_done,
  output logic [NUM_GRP-1:0] repair_fail,
  output logic               busy,
  output logic               all_done,
  output logic               aborted,
  output logic               irq
);

  localparam int IDX_W = $clog2(NUM_GRP + 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_GRP-1:0] r_mask;
  logic               r_en_q;
  logic               r_armed;
  logic [NUM_GRP-1:0] r_req;
  logic [NUM_GRP-1:0] r_done;
  logic [NUM_GRP-1:0] r_fail;
  logic               r_busy;
  logic               r_all_done;
  logic               r_aborted;
  logic               r_irq;

  logic [NUM_GRP-1:0] w_sel;
  logic               w_start;
  logic               w_last;
  logic               w_mask_hit;
  logic               w_ack_hit;
  logic               w_fail_hit;
  logic               w_timeout;

  // r_armed blocks a restart after reset until repair_en has been seen low,
  // so a level held high across reset is not mistaken for a new request.
  assign w_start    = repair_en & ~r_en_q & r_armed;
  assign w_sel      = {{(NUM_GRP-1){1'b0}}, 1'b1} << r_idx;
  assign w_last     = (r_idx == IDX_W'(NUM_GRP));
  assign w_mask_hit = |(r_mask & w_sel);
  assign w_ack_hit  = |(grp_ack & w_sel);
  assign w_fail_hit = |(grp_fail & w_sel);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_mask     <= '0;
      r_en_q     <= 1'b0;
      r_armed    <= 1'b0;
      r_req      <= '0;
      r_done     <= '0;
      r_fail     <= '0;
      r_busy     <= 1'b0;
      r_all_done <= 1'b0;
      r_aborted  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_en_q <= repair_en;
      if (!repair_en) r_armed <= 1'b1;
      r_irq <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_done    <= '0;
            r_fail    <= '0;
            r_aborted <= 1'b0;
            r_mask    <= grp_mask;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (!repair_en) begin
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (w_last) begin
            r_busy     <= 1'b0;
            r_all_done <= 1'b1;
            r_irq      <= 1'b1;
            r_state    <= DONE;
          end else if (!w_mask_hit) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt   <= '0;
            r_req   <= w_sel;
            r_state <= REQ;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // An ack in the same cycle as the timeout or an abort still counts.
          if (w_ack_hit) begin
            r_done  <= r_done | w_sel;
            r_fail  <= (r_fail & ~w_sel) | (w_fail_hit ? w_sel : '0);
            r_req   <= '0;
            r_state <= RELEASE;
            if (!repair_en) r_aborted <= 1'b1;
          end else if (!repair_en) begin
            r_req     <= '0;
            r_aborted <= 1'b1;
            r_state   <= RELEASE;
          end else if (w_timeout) begin
            r_done  <= r_done | w_sel;
            r_fail  <= r_fail | w_sel;
            r_req   <= '0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!w_ack_hit) begin
            if (r_aborted) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= SCAN;
            end
          end
        end
        DONE: begin
          if (!repair_en) begin
            r_all_done <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grp_req     = r_req;
  assign repair_done = r_done;
  assign repair_fail = r_fail;
  assign busy        = r_busy;
  assign all_done    = r_all_done;
  assign aborted     = r_aborted;
  assign irq         = r_irq;

endmodule

// File: tb/tb_mem_repair_seq.sv
// Directed and randomized checks of mem_repair_seq against a group-level
// model of the expected repair outcome, order and handshake lengths.
module tb_mem_repair_seq;

  localparam int NG  = 7;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          repair_en;
  logic [NG-1:0] grp_mask;
  logic [NG-1:0] grp_ack;
  logic [NG-1:0] grp_fail;
  logic [NG-1:0] grp_req;
  logic [NG-1:0] repair_done;
  logic [NG-1:0] repair_fail;
  logic          busy;
  logic          all_done;
  logic          aborted;
  logic          irq;

  mem_repair_seq #(.NUM_GRP(NG), .TIMEOUT(TMO), .CNT_W(16)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .repair_en   (repair_en),
    .grp_mask    (grp_mask),
    .grp_ack     (grp_ack),
    .grp_fail    (grp_fail),
    .grp_req     (grp_req),
    .repair_done (repair_done),
    .repair_fail (repair_fail),
    .busy        (busy),
    .all_done    (all_done),
    .aborted     (aborted),
    .irq         (irq)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;

  // Repair-engine configuration used by the responder.
  logic [NG-1:0] cur_mask  = '0;
  logic [NG-1:0] cfg_never = '0;
  logic [NG-1:0] cfg_fail  = '0;
  int            cfg_delay [NG];
  int            cfg_rel   [NG];
  bit            noise_en  = 1'b0;

  // Observations gathered by the monitor.
  int q_order[$];
  int last_len [NG];
  int irq_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({grp_req, repair_done, repair_fail, busy, all_done, aborted, irq});
  endfunction

  // Responder: acks a request after cfg_delay cycles of req, releases
  // cfg_rel cycles after req drops; groups outside the mask see random noise.
  initial begin
    int hi [NG];
    int rel [NG];
    grp_ack  = '0;
    grp_fail = '0;
    for (int g = 0; g < NG; g++) begin hi[g] = 0; rel[g] = 0; end
    forever begin
      @(negedge pclk);
      for (int g = 0; g < NG; g++) begin
        if (cur_mask[g]) begin
          if (grp_req[g]) begin
            hi[g]++;
            if (!cfg_never[g] && hi[g] == cfg_delay[g]) begin
              grp_ack[g]  = 1'b1;
              grp_fail[g] = cfg_fail[g];
            end
          end else begin
            hi[g] = 0;
            if (grp_ack[g]) begin
              rel[g]++;
              if (rel[g] >= cfg_rel[g]) begin
                grp_ack[g]  = 1'b0;
                grp_fail[g] = 1'b0;
                rel[g]      = 0;
              end
            end
          end
        end else begin
          grp_ack[g]  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
          grp_fail[g] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: request order, request high time, irq pulses, one-hot requests.
  initial begin
    logic [NG-1:0] prev = '0;
    int len [NG];
    for (int g = 0; g < NG; g++) len[g] = 0;
    forever begin
      @(negedge pclk);
      check("req_onehot", 32'($onehot0(grp_req)), 32'd1);
      if (irq) irq_cnt++;
      for (int g = 0; g < NG; g++) begin
        if (grp_req[g] && !prev[g]) q_order.push_back(g);
        if (grp_req[g]) len[g]++;
        else if (prev[g]) begin last_len[g] = len[g]; len[g] = 0; end
      end
      prev = grp_req;
    end
  end

  task automatic wait_all_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge pclk);
      if (all_done) return;
    end
    check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  // One full sequence; expected outcome derived per group from the engine config.
  task automatic run_seq(input string tag, input logic [NG-1:0] mask,
                         input logic [NG-1:0] never, input logic [NG-1:0] failv);
    int exp_order[$];
    cur_mask  = mask;
    cfg_never = never;
    cfg_fail  = failv;
    grp_mask  = mask;
    repeat (4) @(negedge pclk);
    q_order.delete();
    irq_cnt = 0;
    for (int g = 0; g < NG; g++) last_len[g] = -1;
    repair_en = 1'b1;
    @(negedge pclk);
    grp_mask = NG'($urandom);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_status_cleared"}, 32'({repair_done, aborted}), 32'd0);
    wait_all_done(tag);
    @(negedge pclk);
    #1;
    for (int g = 0; g < NG; g++) if (mask[g]) exp_order.push_back(g);
    check({tag, "_done"}, 32'(repair_done), 32'(mask));
    check({tag, "_fail"}, 32'(repair_fail), 32'(mask & (failv | never)));
    check({tag, "_irq_cnt"}, 32'(irq_cnt), 32'd1);
    check({tag, "_busy_end"}, 32'({busy, aborted}), 32'd0);
    check({tag, "_nreq"}, 32'(q_order.size()), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size() && k < q_order.size(); k++)
      check({tag, "_order"}, 32'(q_order[k]), 32'(exp_order[k]));
    for (int g = 0; g < NG; g++)
      if (mask[g])
        check({tag, "_req_len"}, 32'(last_len[g]), 32'(never[g] ? TMO : cfg_delay[g]));
    repair_en = 1'b0;
    repeat (2) @(negedge pclk);
    check({tag, "_all_done_clr"}, 32'(all_done), 32'd0);
    check({tag, "_done_kept"}, 32'(repair_done), 32'(mask));
    $display("seq %s mask=%b never=%b fail=%b -> done=%b fail=%b irq=%0d",
             tag, mask, never, failv, repair_done, repair_fail, irq_cnt);
  endtask

  initial begin
    int busy_cycles;
    logic [NG-1:0] m, nv;
    bit seen;
    preset    = 1'b1;
    repair_en = 1'b0;
    grp_mask  = '0;
    for (int g = 0; g < NG; g++) begin cfg_delay[g] = 3; cfg_rel[g] = 2; end
    repeat (3) @(negedge pclk);
    check("reset_outputs", all_outs(), 32'd0);
    preset = 1'b0;
    repeat (2) @(negedge pclk);

    run_seq("all_groups", 7'h7F, 7'h00, 7'h00);
    run_seq("sparse_fail", 7'b0100101, 7'h00, 7'b0000100);
    run_seq("timeout_g1", 7'b0000111, 7'b0000010, 7'h00);

    // Empty mask: eight SCAN cycles then DONE, status cleared from the last run.
    cur_mask = '0;
    grp_mask = '0;
    irq_cnt  = 0;
    repair_en = 1'b1;
    busy_cycles = 0;
    @(negedge pclk);
    for (int i = 0; i < 50 && busy; i++) begin
      busy_cycles++;
      @(negedge pclk);
    end
    check("empty_busy_cycles", 32'(busy_cycles), 32'(NG + 1));
    check("empty_all_done", 32'(all_done), 32'd1);
    check("empty_status", 32'({repair_done, repair_fail}), 32'd0);
    @(negedge pclk);
    #1;
    check("empty_irq_cnt", 32'(irq_cnt), 32'd1);
    repair_en = 1'b0;
    repeat (2) @(negedge pclk);
    $display("seq empty busy_cycles=%0d irq=%0d", busy_cycles, irq_cnt);

    // Abort while group 3 is being requested.
    cur_mask = 7'h7F;
    cfg_never = '0;
    cfg_fail = '0;
    grp_mask = 7'h7F;
    repeat (4) @(negedge pclk);
    irq_cnt = 0;
    repair_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge pclk);
      seen = grp_req[3];
    end
    check("abort_req3_seen", 32'(seen), 32'd1);
    repair_en = 1'b0;
    @(negedge pclk);
    check("abort_req_drop", 32'(grp_req), 32'd0);
    check("abort_flag", 32'(aborted), 32'd1);
    repeat (3) @(negedge pclk);
    check("abort_idle", 32'({busy, all_done}), 32'd0);
    check("abort_done", 32'(repair_done), 32'h07);
    check("abort_no_irq", 32'(irq_cnt), 32'd0);
    $display("seq abort done=%b aborted=%b irq=%0d", repair_done, aborted, irq_cnt);

    run_seq("after_abort", 7'b1010000, 7'h00, 7'b1000000);

    // Asynchronous reset mid-request; level-high enable must not restart.
    cur_mask = 7'h7F;
    grp_mask = 7'h7F;
    for (int g = 0; g < NG; g++) cfg_delay[g] = 5;
    repeat (4) @(negedge pclk);
    repair_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge pclk);
      seen = (grp_req != '0);
    end
    check("rst_req_seen", 32'(seen), 32'd1);
    #2 preset = 1'b1;
    #1;
    check("rst_async_outputs", all_outs(), 32'd0);
    @(negedge pclk);
    preset = 1'b0;
    repeat (5) @(negedge pclk);
    check("rst_no_restart", 32'({busy, grp_req}), 32'd0);
    repair_en = 1'b0;
    @(negedge pclk);
    repair_en = 1'b1;
    repeat (2) @(negedge pclk);
    check("rst_restart", 32'(busy), 32'd1);
    wait_all_done("rst_seq");
    check("rst_seq_done", 32'(repair_done), 32'h7F);
    repair_en = 1'b0;
    repeat (2) @(negedge pclk);
    $display("seq reset_restart done=%b", repair_done);

    // Randomized sequences with noise on non-participating groups.
    noise_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      m  = NG'($urandom);
      nv = m & NG'($urandom) & NG'($urandom);
      for (int g = 0; g < NG; g++) begin
        cfg_delay[g] = $urandom_range(1, 14);
        cfg_rel[g]   = $urandom_range(1, 3);
      end
      run_seq($sformatf("rand%0d", t), m, nv, NG'($urandom));
    end
    noise_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
